// File: rtl/sh7604_ext_responder_pkg.sv
// Shared types and helpers for the SH7604 external-bus target responder.
package sh7604_ext_responder_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    REQ   = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4,
    ABORT = 3'd5
  } resp_state_t;

  localparam int CNT_W = 3;

  // Byte strobes from the CPU are active low. All-high on a write cycle
  // means the CPU did not qualify bytes, so treat it as a full-word write.
  function automatic logic [3:0] we_to_be(input logic [3:0] we_n);
    logic [3:0] be;
    if (we_n == 4'hF) be = 4'hF;
    else              be = ~we_n;
    return be;
  endfunction

endpackage

// File: rtl/sh7604_ext_responder.sv
// SH7604 external-bus target: one chip-select area mapped onto a
// single-request/ack backend port, with WAIT_N stretching the CPU cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no cycle; waiting for CS_N=0 with BS_N=0
// START | address/direction latched; sample write data/strobes, raise REQ
// REQ   | WAIT_N low; waiting for backend ack and minimum wait count
// DONE  | WAIT_N high; CPU samples read data / completion
// HOLD  | read data held; back-to-back start or return to IDLE
// ABORT | CS_N dropped mid-cycle; REQ kept until the backend acks
module sh7604_ext_responder
  import sh7604_ext_responder_pkg::*;
#(
  parameter int AW       = 22,
  parameter int MIN_WAIT = 1,
  parameter int RD_HOLD  = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE_R,
  input  logic [26:0]   A,
  input  logic [31:0]   BDI,
  output logic [31:0]   BDO,
  input  logic          BS_N,
  input  logic          CS_N,
  input  logic          RD_WR_N,
  input  logic [3:0]    WE_N,
  input  logic          RD_N,
  output logic          WAIT_N,
  output logic [AW-1:0] MEM_A,
  output logic [31:0]   MEM_DO,
  output logic [3:0]    MEM_BE,
  output logic          MEM_WE,
  output logic          MEM_REQ,
  input  logic [31:0]   MEM_DI,
  input  logic          MEM_ACK
);

  localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] RD_HOLD_C  = CNT_W'(RD_HOLD);

  resp_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack_seen;
  logic [31:0]      r_bdo;
  logic             r_wait_n;
  logic [AW-1:0]    r_mem_a;
  logic [31:0]      r_mem_do;
  logic [3:0]       r_mem_be;
  logic             r_mem_we;
  logic             r_mem_req;

  // An ack only counts while a request is outstanding.
  logic w_ack;
  // The counter is tested before its own decrement, so a value of 1
  // means this is the last required tick.
  logic w_cnt_last;
  // RD_N is not needed (direction comes from RD_WR_N); A is only partly used.
  logic w_unused;

  assign w_ack      = MEM_ACK & r_mem_req;
  assign w_cnt_last = (r_cnt <= CNT_W'(1));
  assign w_unused   = &{1'b0, RD_N, A};

  assign BDO     = r_bdo;
  assign WAIT_N  = r_wait_n;
  assign MEM_A   = r_mem_a;
  assign MEM_DO  = r_mem_do;
  assign MEM_BE  = r_mem_be;
  assign MEM_WE  = r_mem_we;
  assign MEM_REQ = r_mem_req;

  // Bus-cycle FSM with wait/hold counter; everything advances on CE_R ticks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack_seen <= 1'b0;
      r_bdo      <= '0;
      r_wait_n   <= 1'b1;
      r_mem_a    <= '0;
      r_mem_do   <= '0;
      r_mem_be   <= '0;
      r_mem_we   <= 1'b0;
      r_mem_req  <= 1'b0;
    end else if (CE_R) begin
      case (r_state)
        IDLE: begin
          if (!CS_N && !BS_N) begin
            r_mem_a  <= A[AW+1:2];
            r_mem_we <= ~RD_WR_N;
            r_state  <= START;
          end
        end
        START: begin
          if (CS_N) begin
            r_wait_n <= 1'b1;
            r_state  <= ABORT;
          end else begin
            r_wait_n   <= 1'b0;
            r_mem_be   <= r_mem_we ? we_to_be(WE_N) : 4'hF;
            if (r_mem_we) r_mem_do <= BDI;
            r_mem_req  <= 1'b1;
            r_cnt      <= MIN_WAIT_C;
            r_ack_seen <= 1'b0;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          if (w_ack) r_mem_req <= 1'b0;
          if (CS_N) begin
            // Read data from a late ack is dropped; REQ stays up until ack.
            r_wait_n <= 1'b1;
            r_state  <= ABORT;
          end else begin
            if (w_ack) r_ack_seen <= 1'b1;
            if (w_ack && !r_mem_we) r_bdo <= MEM_DI;
            if ((r_ack_seen || w_ack) && w_cnt_last) begin
              r_wait_n <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          r_cnt      <= RD_HOLD_C;
          r_ack_seen <= 1'b0;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (CS_N) begin
            r_state <= IDLE;
          end else if (w_cnt_last && !BS_N) begin
            // Back-to-back cycle: skip IDLE and start directly.
            r_mem_a  <= A[AW+1:2];
            r_mem_we <= ~RD_WR_N;
            r_state  <= START;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ABORT: begin
          if (!r_mem_req || w_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sh7604_ext_responder.sv
// Directed bench for sh7604_ext_responder: per-tick vector table for the
// main instance (MIN_WAIT=1) plus hand sequences for write wait counts
// (MIN_WAIT=0/1/3), CE_R stall and mid-cycle reset.
module tb_sh7604_ext_responder;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R, BS_N, CS_N, RD_WR_N, RD_N, MEM_ACK;
  logic [26:0] A;
  logic [31:0] BDI, MEM_DI;
  logic [3:0]  WE_N;

  logic [31:0] BDO, MEM_DO;
  logic        WAIT_N, MEM_WE, MEM_REQ;
  logic [21:0] MEM_A;
  logic [3:0]  MEM_BE;

  logic [31:0] d0_bdo, d0_mem_do, d3_bdo, d3_mem_do;
  logic        d0_wait_n, d0_mem_we, d0_mem_req, d3_wait_n, d3_mem_we, d3_mem_req;
  logic [21:0] d0_mem_a, d3_mem_a;
  logic [3:0]  d0_mem_be, d3_mem_be;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sh7604_ext_responder #(.AW(22), .MIN_WAIT(1), .RD_HOLD(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .A(A), .BDI(BDI), .BDO(BDO),
    .BS_N(BS_N), .CS_N(CS_N), .RD_WR_N(RD_WR_N), .WE_N(WE_N), .RD_N(RD_N),
    .WAIT_N(WAIT_N), .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE),
    .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ), .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK));

  sh7604_ext_responder #(.AW(22), .MIN_WAIT(0), .RD_HOLD(1)) dut_w0 (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .A(A), .BDI(BDI), .BDO(d0_bdo),
    .BS_N(BS_N), .CS_N(CS_N), .RD_WR_N(RD_WR_N), .WE_N(WE_N), .RD_N(RD_N),
    .WAIT_N(d0_wait_n), .MEM_A(d0_mem_a), .MEM_DO(d0_mem_do), .MEM_BE(d0_mem_be),
    .MEM_WE(d0_mem_we), .MEM_REQ(d0_mem_req), .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK));

  sh7604_ext_responder #(.AW(22), .MIN_WAIT(3), .RD_HOLD(1)) dut_w3 (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .A(A), .BDI(BDI), .BDO(d3_bdo),
    .BS_N(BS_N), .CS_N(CS_N), .RD_WR_N(RD_WR_N), .WE_N(WE_N), .RD_N(RD_N),
    .WAIT_N(d3_wait_n), .MEM_A(d3_mem_a), .MEM_DO(d3_mem_do), .MEM_BE(d3_mem_be),
    .MEM_WE(d3_mem_we), .MEM_REQ(d3_mem_req), .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK));

  typedef struct {
    string       tag;
    logic        cs_n, bs_n, rd_wr_n, ack;
    logic [26:0] a;
    logic [31:0] di;
    logic        e_wait_n, e_req, e_we;
    logic [3:0]  e_be;
    logic [21:0] e_a;
    logic [31:0] e_bdo;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string tag, input logic cs_n, input logic bs_n,
                     input logic rd_wr_n, input logic [26:0] a, input logic ack,
                     input logic [31:0] di, input logic e_wait_n, input logic e_req,
                     input logic e_we, input logic [3:0] e_be, input logic [21:0] e_a,
                     input logic [31:0] e_bdo);
    vec_t v;
    v.tag = tag; v.cs_n = cs_n; v.bs_n = bs_n; v.rd_wr_n = rd_wr_n; v.a = a;
    v.ack = ack; v.di = di; v.e_wait_n = e_wait_n; v.e_req = e_req; v.e_we = e_we;
    v.e_be = e_be; v.e_a = e_a; v.e_bdo = e_bdo;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      CS_N = vq[i].cs_n; BS_N = vq[i].bs_n; RD_WR_N = vq[i].rd_wr_n;
      A = vq[i].a; MEM_ACK = vq[i].ack; MEM_DI = vq[i].di;
      WE_N = 4'hF; BDI = 32'h0; CE_R = 1'b1;
      step();
      chk($sformatf("vec%0d_%s", i, vq[i].tag),
          128'({WAIT_N, MEM_REQ, MEM_WE, MEM_BE, MEM_A, BDO}),
          128'({vq[i].e_wait_n, vq[i].e_req, vq[i].e_we, vq[i].e_be, vq[i].e_a, vq[i].e_bdo}));
    end
    MEM_ACK = 1'b0;
  endtask

  function automatic logic [127:0] main_outs();
    return 128'({WAIT_N, MEM_REQ, MEM_WE, MEM_BE, MEM_A, BDO, MEM_DO});
  endfunction

  localparam logic [127:0] RESET_OUTS =
    128'({1'b1, 1'b0, 1'b0, 4'h0, 22'h0, 32'h0, 32'h0});

  int lo0, lo1, lo3;

  initial begin
    RST_N = 1'b0; CE_R = 1'b1; CS_N = 1'b1; BS_N = 1'b1; RD_WR_N = 1'b1; RD_N = 1'b1;
    WE_N = 4'hF; A = '0; BDI = '0; MEM_DI = '0; MEM_ACK = 1'b0;

    // Word read: ack 3 ticks after REQ, WAIT_N low 4 ticks (rows 0..8)
    add("rd_start", 0, 0, 1, 27'h10, 0, 32'h0,        1, 0, 0, 4'h0, 22'h4, 32'h0);
    add("rd_req",   0, 1, 1, 27'h10, 0, 32'h0,        0, 1, 0, 4'hF, 22'h4, 32'h0);
    add("rd_w1",    0, 1, 1, 27'h10, 0, 32'h0,        0, 1, 0, 4'hF, 22'h4, 32'h0);
    add("rd_w2",    0, 1, 1, 27'h10, 0, 32'h0,        0, 1, 0, 4'hF, 22'h4, 32'h0);
    add("rd_w3",    0, 1, 1, 27'h10, 0, 32'h0,        0, 1, 0, 4'hF, 22'h4, 32'h0);
    add("rd_ack",   0, 1, 1, 27'h10, 1, 32'hDEADBEEF, 1, 0, 0, 4'hF, 22'h4, 32'hDEADBEEF);
    add("rd_done",  0, 1, 1, 27'h10, 0, 32'h0,        1, 0, 0, 4'hF, 22'h4, 32'hDEADBEEF);
    add("rd_hold",  0, 1, 1, 27'h10, 0, 32'h0,        1, 0, 0, 4'hF, 22'h4, 32'hDEADBEEF);
    add("rd_csoff", 1, 1, 1, 27'h10, 0, 32'h0,        1, 0, 0, 4'hF, 22'h4, 32'hDEADBEEF);
    // Back-to-back reads, second BS_N in the first HOLD tick
    add("b2b_start", 0, 0, 1, 27'h20, 0, 32'h0,       1, 0, 0, 4'hF, 22'h8, 32'hDEADBEEF);
    add("b2b_req",   0, 1, 1, 27'h20, 0, 32'h0,       0, 1, 0, 4'hF, 22'h8, 32'hDEADBEEF);
    add("b2b_w1",    0, 1, 1, 27'h20, 0, 32'h0,       0, 1, 0, 4'hF, 22'h8, 32'hDEADBEEF);
    add("b2b_ack1",  0, 1, 1, 27'h20, 1, 32'h11111111, 1, 0, 0, 4'hF, 22'h8, 32'h11111111);
    add("b2b_done1", 0, 1, 1, 27'h20, 0, 32'h0,       1, 0, 0, 4'hF, 22'h8, 32'h11111111);
    add("b2b_bs2",   0, 0, 1, 27'h30, 0, 32'h0,       1, 0, 0, 4'hF, 22'hC, 32'h11111111);
    add("b2b_req2",  0, 1, 1, 27'h30, 0, 32'h0,       0, 1, 0, 4'hF, 22'hC, 32'h11111111);
    add("b2b_ack2",  0, 1, 1, 27'h30, 1, 32'h22222222, 1, 0, 0, 4'hF, 22'hC, 32'h22222222);
    add("b2b_done2", 0, 1, 1, 27'h30, 0, 32'h0,       1, 0, 0, 4'hF, 22'hC, 32'h22222222);
    add("b2b_off",   1, 1, 1, 27'h30, 0, 32'h0,       1, 0, 0, 4'hF, 22'hC, 32'h22222222);
    // Abort: CS_N rises 2 ticks into REQ, ack 5 ticks later, new BS_N meanwhile
    add("ab_start",  0, 0, 1, 27'h50, 0, 32'h0,       1, 0, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_req",    0, 1, 1, 27'h50, 0, 32'h0,       0, 1, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_w1",     0, 1, 1, 27'h50, 0, 32'h0,       0, 1, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_w2",     0, 1, 1, 27'h50, 0, 32'h0,       0, 1, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_csoff",  1, 1, 1, 27'h50, 0, 32'h0,       1, 1, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_wait",   1, 1, 1, 27'h50, 0, 32'h0,       1, 1, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_newbs1", 0, 0, 1, 27'h60, 0, 32'h0,       1, 1, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_newbs2", 0, 0, 1, 27'h60, 0, 32'h0,       1, 1, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_ack",    0, 0, 1, 27'h60, 1, 32'h33333333, 1, 0, 0, 4'hF, 22'h14, 32'h22222222);
    add("ab_accept", 0, 0, 1, 27'h60, 0, 32'h0,       1, 0, 0, 4'hF, 22'h18, 32'h22222222);
    add("ab_req2",   0, 1, 1, 27'h60, 0, 32'h0,       0, 1, 0, 4'hF, 22'h18, 32'h22222222);
    add("ab_ack2",   0, 1, 1, 27'h60, 1, 32'h44444444, 1, 0, 0, 4'hF, 22'h18, 32'h44444444);
    add("ab_done2",  1, 1, 1, 27'h60, 0, 32'h0,       1, 0, 0, 4'hF, 22'h18, 32'h44444444);
    add("ab_idle",   1, 1, 1, 27'h60, 0, 32'h0,       1, 0, 0, 4'hF, 22'h18, 32'h44444444);
    // Stray ack in IDLE, BS_N with CS_N high
    add("st_bs_nocs", 1, 0, 1, 27'h70, 1, 32'h55555555, 1, 0, 0, 4'hF, 22'h18, 32'h44444444);
    add("st_ack",     0, 1, 1, 27'h70, 1, 32'h55555555, 1, 0, 0, 4'hF, 22'h18, 32'h44444444);
    add("st_quiet",   1, 1, 1, 27'h70, 0, 32'h0,        1, 0, 0, 4'hF, 22'h18, 32'h44444444);

    step(); step();
    chk("reset_outs", main_outs(), RESET_OUTS);
    RST_N = 1'b1;
    step();

    apply_rows(0, vq.size() - 1);

    // Byte write on all three instances, ack on the first REQ tick
    CS_N = 1'b1; step();
    CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b0; A = 27'h40; step();
    BS_N = 1'b1; WE_N = 4'b1011; BDI = 32'h00AB0000; step();
    chk("wr_start_main", 128'({MEM_WE, MEM_BE, MEM_A, MEM_DO, MEM_REQ, WAIT_N}),
        128'({1'b1, 4'b0100, 22'h10, 32'h00AB0000, 1'b1, 1'b0}));
    chk("wr_start_d3", 128'({d3_mem_we, d3_mem_be, d3_mem_do, d3_wait_n}),
        128'({1'b1, 4'b0100, 32'h00AB0000, 1'b0}));
    lo0 = (d0_wait_n == 1'b0) ? 1 : 0;
    lo1 = (WAIT_N == 1'b0) ? 1 : 0;
    lo3 = (d3_wait_n == 1'b0) ? 1 : 0;
    WE_N = 4'hF; BDI = 32'hFFFFFFFF;
    for (int k = 0; k < 6; k++) begin
      MEM_ACK = (k == 0);
      step();
      if (k == 0)
        chk("wr_d3_req_drop", 128'({d3_mem_req, d3_wait_n, MEM_REQ}), 128'({1'b0, 1'b0, 1'b0}));
      lo0 += (d0_wait_n == 1'b0) ? 1 : 0;
      lo1 += (WAIT_N == 1'b0) ? 1 : 0;
      lo3 += (d3_wait_n == 1'b0) ? 1 : 0;
    end
    MEM_ACK = 1'b0;
    chk("wr_wait_min0", 128'(lo0), 128'(1));
    chk("wr_wait_min1", 128'(lo1), 128'(1));
    chk("wr_wait_min3", 128'(lo3), 128'(3));
    chk("wr_do_held", 128'({MEM_DO, BDO}), 128'({32'h00AB0000, 32'h44444444}));
    CS_N = 1'b1; step(); step();

    // Write with all strobes high falls back to a full-word write
    CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b0; A = 27'h44; step();
    BS_N = 1'b1; WE_N = 4'hF; BDI = 32'hCAFEF00D; step();
    chk("wr_full_fallback", 128'({MEM_WE, MEM_BE, MEM_A, MEM_DO}),
        128'({1'b1, 4'hF, 22'h11, 32'hCAFEF00D}));
    MEM_ACK = 1'b1; step(); MEM_ACK = 1'b0;
    CS_N = 1'b1; step(); step(); step();

    // CE_R low freezes the cycle even with an ack present
    CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b1; A = 27'h80; step();
    BS_N = 1'b1; step();
    CE_R = 1'b0; MEM_ACK = 1'b1; MEM_DI = 32'h66666666;
    step(); step(); step();
    chk("ce_stall", 128'({WAIT_N, MEM_REQ, MEM_A, BDO}), 128'({1'b0, 1'b1, 22'h20, 32'h44444444}));
    CE_R = 1'b1; step();
    chk("ce_resume", 128'({WAIT_N, MEM_REQ, BDO}), 128'({1'b1, 1'b0, 32'h66666666}));
    MEM_ACK = 1'b0; MEM_DI = '0;
    CS_N = 1'b1; step(); step(); step();

    // Reset pulsed mid-REQ: outputs clear without a clock edge
    CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b0; A = 27'h100; step();
    BS_N = 1'b1; WE_N = 4'h0; BDI = 32'h12345678; step();
    step();
    chk("pre_reset_busy", 128'({WAIT_N, MEM_REQ, MEM_DO}), 128'({1'b0, 1'b1, 32'h12345678}));
    #2 RST_N = 1'b0;
    #1 chk("async_reset_main", main_outs(), RESET_OUTS);
    chk("async_reset_d3", 128'({d3_wait_n, d3_mem_req, d3_mem_we, d3_mem_be, d3_mem_a, d3_bdo, d3_mem_do}),
        RESET_OUTS);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    CS_N = 1'b1; WE_N = 4'hF; step();
    apply_rows(0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
